// File: rtl/delay_fifo_seq.sv
// delay_fifo_seq: burst sequencer feeding a delay_fifo from a source memory and framing the delayed return stream.
// Define DELAY_SEQ_TIMEOUT_EN to add a drain watchdog that aborts a burst whose returns stall.
module delay_fifo_seq #(
  parameter int DELAY_CYCLES = 1,
  parameter int BITWIDTH = 32,
  parameter int ADDRWIDTH = 4,
  parameter int LENWIDTH = ADDRWIDTH + 1
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 start,
  input  logic [ADDRWIDTH-1:0] base_addr,
  input  logic [LENWIDTH-1:0]  len,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 mem_rd,
  output logic [ADDRWIDTH-1:0] mem_addr,
  input  logic [BITWIDTH-1:0]  mem_rdata,
  output logic                 fifo_en,
  output logic [BITWIDTH-1:0]  fifo_din,
  output logic                 fifo_valid,
  input  logic [BITWIDTH-1:0]  fifo_dout,
  input  logic                 fifo_dvalid,
  output logic [BITWIDTH-1:0]  out_data,
  output logic                 out_valid,
  output logic                 out_last
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [ADDRWIDTH-1:0] base;
  logic [LENWIDTH-1:0] blen, issue_cnt, ret_cnt;
  logic rd_d1, active, accept, ret_ok, ovf, tmo;
  assign active = state == ISSUE || state == DRAIN;
  assign accept = state == IDLE && start;
  assign ret_ok = active && fifo_dvalid && ret_cnt != blen;
  assign ovf = active && fifo_dvalid && ret_cnt == blen;
  assign mem_rd = state == ISSUE;
  assign mem_addr = mem_rd ? base + issue_cnt[ADDRWIDTH-1:0] : '0;
  assign fifo_en = active;
  assign busy = state != IDLE;
  assign done = state == DONE;
`ifdef DELAY_SEQ_TIMEOUT_EN
  localparam int WDW = $clog2(DELAY_CYCLES + 6);
  logic [WDW-1:0] wd;
  // Counts silent cycles while words are outstanding; runs through ISSUE so a stall that starts early is caught.
  always_ff @(posedge aclk or posedge areset)
    if (areset) wd <= '0;
    else if (accept || fifo_dvalid) wd <= '0;
    else if (active && ret_cnt != blen) wd <= wd + WDW'(1);
  assign tmo = state == DRAIN && !fifo_dvalid && ret_cnt != blen && wd == WDW'(DELAY_CYCLES + 2);
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = start ? (len == '0 ? DONE : ISSUE) : IDLE;
      ISSUE: state_nx = issue_cnt == blen - LENWIDTH'(1) ? DRAIN : ISSUE;
      DRAIN: state_nx = ret_cnt == blen || tmo ? DONE : DRAIN;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      state <= IDLE;
      base <= '0;
      blen <= '0;
      issue_cnt <= '0;
      ret_cnt <= '0;
      err <= 1'b0;
      rd_d1 <= 1'b0;
      fifo_valid <= 1'b0;
      fifo_din <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
    end else begin
      state <= state_nx;
      rd_d1 <= mem_rd;
      fifo_valid <= rd_d1;
      fifo_din <= rd_d1 ? mem_rdata : '0;
      out_data <= ret_ok ? fifo_dout : '0;
      out_valid <= ret_ok;
      out_last <= ret_ok && ret_cnt == blen - LENWIDTH'(1);
      if (accept) begin
        base <= base_addr;
        blen <= len;
        issue_cnt <= '0;
        ret_cnt <= '0;
        err <= 1'b0;
      end else begin
        if (mem_rd) issue_cnt <= issue_cnt + LENWIDTH'(1);
        if (ret_ok) ret_cnt <= ret_cnt + LENWIDTH'(1);
        if (ovf || tmo) err <= 1'b1;
      end
    end
endmodule
